// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the mem_bank operand/result store.
// Optional per-byte parity storage is enabled with `define MEM_BANK_PARITY_EN.
package mem_bank_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    // Upper bound on word width handled by byte_parity; callers zero-extend and truncate.
    localparam int PAR_MAX_W = 1024;
    localparam int PAR_MAX_B = PAR_MAX_W / 8;

    function automatic logic [PAR_MAX_B-1:0] byte_parity(input logic [PAR_MAX_W-1:0] data);
        logic [PAR_MAX_B-1:0] par;
        for (int i = 0; i < PAR_MAX_B; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/mem_bank_array.sv
// Plain synchronous word array: one byte-lane-enabled write port, one registered read port.
// Lane width is a parameter so parity bits can travel alongside each byte.
module mem_bank_array #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [LANES-1:0]         i_be,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [LANES*LANE_W-1:0]  i_wdata,
    input  logic                     i_re,
    output logic [LANES*LANE_W-1:0]  o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [LANES*LANE_W-1:0] r_mem [DEPTH];
    logic [LANES*LANE_W-1:0] r_rdata;

    // NOTE: the array and its read register carry no reset so the tools can map them onto RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bank.sv
// Single-port operand/result store with valid/ready requests, 1-cycle read response and
// a sequential clear FSM. Define MEM_BANK_PARITY_EN to add per-byte parity and rsp_err.
module mem_bank
    import mem_bank_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               ADDR_W   = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [WIDTH-1:0]    req_wdata,
    input  logic [WIDTH/8-1:0]  req_be,
    output logic                rsp_valid,
    output logic [WIDTH-1:0]    rsp_rdata,
`ifdef MEM_BANK_PARITY_EN
    output logic                rsp_err,
`endif
    output logic                init_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / 8;
`ifdef MEM_BANK_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int MEM_W = NB * LANE_W;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_init_cnt, w_cnt_nxt;
    logic                r_rsp_valid;
    logic [WIDTH-1:0]    r_rdata_hold;

    logic                w_req_ready;
    logic                w_accept;
    logic                w_rd;
    logic                w_in_init;
    logic                w_arr_we;
    logic [NB-1:0]       w_arr_be;
    logic [ADDR_W-1:0]   w_arr_addr;
    logic [MEM_W-1:0]    w_arr_wdata;
    logic [MEM_W-1:0]    w_arr_rdata;
    logic [MEM_W-1:0]    w_init_word;
    logic [MEM_W-1:0]    w_req_word;
    logic [WIDTH-1:0]    w_rd_data;

`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0] w_init_par, w_req_par, w_rd_par, w_rd_calc;

    assign w_init_par = NB'(byte_parity(PAR_MAX_W'(INIT_VAL)));
    assign w_req_par  = NB'(byte_parity(PAR_MAX_W'(req_wdata)));
    assign w_rd_calc  = NB'(byte_parity(PAR_MAX_W'(w_rd_data)));

    // Each lane is stored as {even parity, byte}.
    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign w_init_word[g*LANE_W +: LANE_W] = {w_init_par[g], INIT_VAL[g*8 +: 8]};
        assign w_req_word[g*LANE_W +: LANE_W]  = {w_req_par[g], req_wdata[g*8 +: 8]};
        assign w_rd_data[g*8 +: 8]             = w_arr_rdata[g*LANE_W +: 8];
        assign w_rd_par[g]                     = w_arr_rdata[g*LANE_W + 8];
    end

    assign rsp_err = r_rsp_valid & (|(w_rd_par ^ w_rd_calc));
`else
    assign w_init_word = INIT_VAL;
    assign w_req_word  = req_wdata;
    assign w_rd_data   = w_arr_rdata;
`endif

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_init_cnt;
        w_req_ready = 1'b0;
        case (r_state)
            S_INIT: begin
                w_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                // clear takes priority over any request presented in the same cycle
                w_req_ready = ~clear;
                if (clear) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    assign w_in_init   = (r_state == S_INIT);
    assign w_accept    = req_valid & w_req_ready;
    assign w_rd        = w_accept & ~req_we;
    assign w_arr_we    = w_in_init | (w_accept & req_we);
    assign w_arr_be    = w_in_init ? {NB{1'b1}} : req_be;
    assign w_arr_addr  = w_in_init ? r_init_cnt : req_addr;
    assign w_arr_wdata = w_in_init ? w_init_word : w_req_word;

    mem_bank_array #(
        .LANES  (NB),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .i_re    (w_rd),
        .o_rdata (w_arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_INIT;
            r_init_cnt   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_cnt_nxt;
            r_rsp_valid <= w_rd;
            if (r_rsp_valid) begin
                r_rdata_hold <= w_rd_data;
            end
        end
    end

    // The RAM read register is unreset, so a resettable copy supplies the held value.
    assign rsp_rdata = r_rsp_valid ? w_rd_data : r_rdata_hold;
    assign rsp_valid = r_rsp_valid;
    assign req_ready = w_req_ready;
    assign init_done = (r_state == S_RUN);

endmodule

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank (WIDTH=32, ADDR_W=8): table-driven requests plus
// hand-written init, clear and reset sequences.
module tb_mem_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        init_done;
`ifdef MEM_BANK_PARITY_EN
    logic        rsp_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bank #(
        .WIDTH    (32),
        .ADDR_W   (8),
        .INIT_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef MEM_BANK_PARITY_EN
        .rsp_err   (rsp_err),
`endif
        .init_done (init_done)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges from the current point; init_done must rise exactly at the 256th.
    task automatic wait_init(input string name, input int clear_at);
        logic early;
        early = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            clear = (i == clear_at);
            @(posedge clk);
            #1;
            if (i < 256 && (init_done || req_ready)) early = 1'b1;
        end
        clear = 1'b0;
        check({name, "_early"}, 64'(early), 64'd0);
        check({name, "_done"}, 64'(init_done), 64'd1);
        check({name, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic do_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 64'(rsp_valid), 64'd1);
        check({name, "_data"}, 64'(rsp_rdata), 64'(exp));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 32'h0000_0000};
        vecs[1]  = '{1'b0, 8'h80, 32'h0,        4'h0, 1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b0, 8'h05, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 8'h05, 32'h12345678, 4'h3, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 8'h05, 32'h0,        4'h0, 1'b1, 32'hDEAD5678};
        vecs[7]  = '{1'b1, 8'h05, 32'hFFFFFFFF, 4'h0, 1'b0, 32'hDEAD5678};
        vecs[8]  = '{1'b0, 8'h05, 32'h0,        4'h0, 1'b1, 32'hDEAD5678};
        vecs[9]  = '{1'b1, 8'hFF, 32'hA5A5A5A5, 4'hC, 1'b0, 32'hDEAD5678};
        vecs[10] = '{1'b1, 8'h00, 32'hCAFEF00D, 4'h8, 1'b0, 32'hDEAD5678};
        vecs[11] = '{1'b0, 8'h05, 32'h0,        4'h0, 1'b1, 32'hDEAD5678};
        vecs[12] = '{1'b0, 8'hFF, 32'h0,        4'h0, 1'b1, 32'hA5A50000};
        vecs[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 32'hCA000000};

        reset     = 1'b1;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;

        #23;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        @(negedge clk);
        reset = 1'b0;
        wait_init("init1", 0);

        // Back-to-back requests, one per cycle, response sampled after each edge.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = vecs[i].we;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            req_be    = vecs[i].be;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 64'(rsp_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 64'(rsp_rdata), 64'(vecs[i].exp_rdata));
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(posedge clk);
        #1;
        check("idle_valid", 64'(rsp_valid), 64'd0);
        check("idle_hold", 64'(rsp_rdata), 64'hCA000000);

        // Read accepted, then clear with a new request the following cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h05;
        @(posedge clk);
        #1;
        check("preclr_valid", 64'(rsp_valid), 64'd1);
        check("preclr_data", 64'(rsp_rdata), 64'hDEAD5678);
        @(negedge clk);
        req_addr = 8'hFF;
        clear    = 1'b1;
        #1;
        check("clr_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("clr_no_rsp", 64'(rsp_valid), 64'd0);
        check("clr_done_fall", 64'(init_done), 64'd0);
        req_valid = 1'b0;
        clear     = 1'b0;
        // A second clear during the init must not restart the counter.
        wait_init("init_clr", 100);
        do_read("clr_rd05", 8'h05, 32'h0);
        do_read("clr_rdff", 8'hFF, 32'h0);

        // Reset while a read response is pending, then again at init cycle 100.
        do_write(8'h05, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h05;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rstrd_valid", 64'(rsp_valid), 64'd0);
        check("rstrd_data", 64'(rsp_rdata), 64'd0);
        check("rstrd_done", 64'(init_done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst100_done", 64'(init_done), 64'd0);
        check("rst100_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("init_rst", 0);
        do_read("rst_rd05", 8'h05, 32'h0);

`ifdef MEM_BANK_PARITY_EN
        do_write(8'h05, 32'h00FF00FF, 4'hF);
        do_read("par_clean", 8'h05, 32'h00FF00FF);
        check("par_clean_err_idle", 64'(rsp_err), 64'd0);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h05;
        @(posedge clk);
        #1;
        check("par_clean_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        dut.u_array.r_mem[5][0] = ~dut.u_array.r_mem[5][0];
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h05;
        @(posedge clk);
        #1;
        check("par_bad_err", 64'(rsp_err), 64'd1);
        @(negedge clk);
        req_addr = 8'hFF;
        @(posedge clk);
        #1;
        check("par_ok_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
